xf100_exu_iq: RTL
=================

Name: xf100_exu_iq

Overview:
- Instruction queue at the front of the exu; receiving end of the ifu->exu instruction/PC stream.
- Accepts {instr, pc} pairs from the ifu over a valid/ready handshake and buffers up to DEPTH entries.
- Presents the oldest entry to exu decode over a second valid/ready handshake.
- A flush (branch/exception redirect) discards all buffered entries.

Parameters:
- DEPTH, 4, number of entries; power of 2, >= 2.
- INSTR_W, `XF100_INSTR_SIZE, instruction width.
- PC_W, `XF100_PC_SIZE, PC width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- iq_i_valid  in  1  ifu has an entry to push.
- iq_o_ready  out  1  queue can accept a push this cycle.
- iq_i_instr  in  INSTR_W  pushed instruction.
- iq_i_pc  in  PC_W  pushed PC.
- iq_o_valid  out  1  head entry available to exu.
- iq_i_ready  in  1  exu consumes head this cycle.
- iq_o_instr  out  INSTR_W  head instruction.
- iq_o_pc  out  PC_W  head PC.
- iq_i_flush  in  1  discard all entries.
- iq_o_count  out  $clog2(DEPTH+1)  current occupancy.
- iq_o_full  out  1  count == DEPTH.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: wptr=0, rptr=0, count=0, so iq_o_valid=0, iq_o_ready=1, iq_o_full=0, iq_o_count=0. iq_o_instr/iq_o_pc reset to 0. Storage array is not reset.
- push = iq_i_valid & iq_o_ready. pop = iq_o_valid & iq_i_ready.
- iq_o_ready = ~full, driven from registered count only. It has no combinational dependency on iq_i_ready, so a full queue does not accept a push in the same cycle as a pop.
- iq_o_valid = (count != 0). iq_o_instr/iq_o_pc = mem[rptr] (first-word-fall-through from registers).
- Latency: entry pushed in cycle N is visible at the output in cycle N+1 at the earliest. There is no combinational input->output bypass.
- Push: mem[wptr] <= {instr,pc}; wptr <= wptr+1 mod DEPTH.
- Pop: rptr <= rptr+1 mod DEPTH.
- Count: push&~pop: +1. pop&~push: -1. Both or neither: unchanged.
- Wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are distinguished by count, never by pointer equality.
- Flush, priority over everything: next cycle wptr=rptr=0 and count=0. Any push and pop in the flush cycle are ignored, and the pushed entry is dropped.
- Rst takes priority over flush.
- Ordering: strict FIFO; entries leave in push order.
- Output stability: while iq_o_valid=1 and iq_i_ready=0, iq_o_instr/iq_o_pc hold constant until pop or flush.
- Illegal use: the ifu must hold iq_i_instr/iq_i_pc stable while iq_i_valid=1 and iq_o_ready=0. No internal check is required.
- Simulation assertions (not synthesized): count never exceeds DEPTH; no pop while empty.

Decomposition:
- Add `XF100_IQ_DEPTH (default 4) to xf100_defines.v, used by the exu instantiation.
- Queue entry = {pc, instr}, packed PC high. Define `XF100_IQ_ENTRY_SIZE = `XF100_PC_SIZE + `XF100_INSTR_SIZE in xf100_defines.v.
- No sub-module: storage array, pointers and count are small enough to live inline.
- Core top integration: insert between u_xf100_ifu and u_xf100_exu.

Test Plan:
- Reset then idle: assert rst 2 cycles -> iq_o_valid=0, iq_o_ready=1, iq_o_count=0, iq_o_instr=0, iq_o_pc=0.
- Single push: push instr=0x00500093, pc=0x80000000 in cycle N, iq_i_ready=0 -> cycle N+1: iq_o_valid=1 with those values, count=1; values held for 5 cycles.
- Fill and wrap:
  - push 4 entries (pc 0x0,0x4,0x8,0xC) with iq_i_ready=0 -> count=4, iq_o_full=1, iq_o_ready=0; 5th push (pc 0x10) is not accepted.
  - Pop 2, push 0x10 and 0x14, then drain -> output order 0x0,0x4,0x8,0xC,0x10,0x14.
- Simultaneous push/pop at count=2: one cycle with push and pop -> count stays 2, head advances to the next pc.
- Flush mid-stream: count=3 with push asserted in the flush cycle -> next cycle count=0, iq_o_valid=0, pushed entry absent. A following push of pc 0x100 appears alone at the head.
- Reset mid-operation: count=3, assert rst for 1 cycle together with push and flush -> next cycle count=0, outputs 0, iq_o_ready=1.

Source files
------------

// File: rtl/xf100_exu_iq_pkg.sv
// xf100_exu_iq_pkg
// Shared sizing for the exu instruction queue: instruction/PC widths of the
// ifu->exu stream, default queue depth, and the packed entry width.
// A queue entry is {pc, instr}, with the PC in the high bits.
package xf100_exu_iq_pkg;

    localparam int XF100_INSTR_SIZE    = 32;
    localparam int XF100_PC_SIZE       = 32;
    localparam int XF100_IQ_DEPTH      = 4;
    localparam int XF100_IQ_ENTRY_SIZE = XF100_PC_SIZE + XF100_INSTR_SIZE;

endpackage : xf100_exu_iq_pkg

// File: rtl/xf100_exu_iq.sv
// xf100_exu_iq
// Instruction queue at the front of the exu. Buffers {instr, pc} pairs pushed
// by the ifu and presents the oldest one to exu decode, first-word-fall-through
// from the storage registers. A flush discards every buffered entry.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   iq_i_valid/ready  push handshake from the ifu (iq_o_ready out)
//   iq_i_instr/pc     pushed entry
//   iq_o_valid        head entry available to decode (iq_i_ready consumes it)
//   iq_o_instr/pc     head entry (0 while empty)
//   iq_i_flush        discard all entries, wins over push and pop
//   iq_o_count        occupancy, iq_o_full when count == DEPTH
module xf100_exu_iq
    import xf100_exu_iq_pkg::*;
#(
    parameter int DEPTH   = XF100_IQ_DEPTH,
    parameter int INSTR_W = XF100_INSTR_SIZE,
    parameter int PC_W    = XF100_PC_SIZE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       iq_i_valid,
    output logic                       iq_o_ready,
    input  logic [INSTR_W-1:0]         iq_i_instr,
    input  logic [PC_W-1:0]            iq_i_pc,
    output logic                       iq_o_valid,
    input  logic                       iq_i_ready,
    output logic [INSTR_W-1:0]         iq_o_instr,
    output logic [PC_W-1:0]            iq_o_pc,
    input  logic                       iq_i_flush,
    output logic [$clog2(DEPTH+1)-1:0] iq_o_count,
    output logic                       iq_o_full
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH+1);
    localparam int ENTRY_W = PC_W + INSTR_W;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ENTRY_W-1:0] head;
    logic               push, pop;

    // Ready comes from registered occupancy only, so a full queue never
    // accepts a push in the same cycle as a pop.
    assign iq_o_full  = (count_q == CNT_W'(DEPTH));
    assign iq_o_ready = ~iq_o_full;
    assign iq_o_valid = (count_q != '0);
    assign iq_o_count = count_q;

    assign push = iq_i_valid & iq_o_ready;
    assign pop  = iq_o_valid & iq_i_ready;

    // Empty queue drives zeros so the outputs are clean after reset/flush
    // even though the storage itself is never reset.
    assign head       = mem_q[rptr_q];
    assign iq_o_instr = iq_o_valid ? head[INSTR_W-1:0]       : '0;
    assign iq_o_pc    = iq_o_valid ? head[ENTRY_W-1:INSTR_W] : '0;

    // Next pointers and occupancy. Full vs empty is told apart by count,
    // never by pointer equality; pointers wrap naturally at DEPTH.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (iq_i_flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + PTR_W'(1);
            if (pop)  rptr_d = rptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    // Control state; reset wins over flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage; a push coinciding with reset or flush is dropped.
    always_ff @(posedge clk) begin
        if (!rst && !iq_i_flush && push) begin
            mem_q[wptr_q] <= {iq_i_pc, iq_i_instr};
        end
    end

    a_count_le_depth: assert property (@(posedge clk) disable iff (rst)
        count_q <= CNT_W'(DEPTH));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
        pop |-> (count_q != '0));

endmodule : xf100_exu_iq
